// File: rtl/issue_queue.sv
// Collapsing issue queue between Rename and EXE.
// Slot 0 holds the oldest entry; slots 0..iq_count-1 are occupied. Each slot
// tracks readiness of its two physical sources. The oldest ready slot is
// presented to EXE, and the queue collapses when that slot leaves.
module issue_queue #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 170,
   parameter int PREGS = 64
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     FLUSH,
   input  logic                     entry_allocate_issue,
   input  logic [WIDTH-1:0]         entry_issue,
   input  logic [PREGS-1:0]         busy,
   input  logic                     wb_valid,
   input  logic [5:0]               wb_reg,
   input  logic                     exe_ready,
   output logic                     issue_valid,
   output logic [WIDTH-1:0]         issue_entry,
   output logic                     issue_halt,
   output logic [$clog2(DEPTH):0]   iq_count,
   output logic                     overflow_err
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [WIDTH-1:0] entry_d [DEPTH];
   logic [DEPTH-1:0] rdya_q, rdya_d;
   logic [DEPTH-1:0] rdyb_q, rdyb_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;

   logic             sel_found;
   logic [CW-1:0]    sel_idx;
   logic             do_issue;
   logic             wb_hit;
   logic             alloc_ok;
   logic [CW-1:0]    count_after;

   // A source is ready if it is preg 0, not busy, or being written back this edge.
   function automatic logic src_ready(input logic [5:0] m, input logic [PREGS-1:0] b,
                                      input logic wv, input logic [5:0] wr);
      return (m == 6'd0) || !b[m] || (wv && (wr == m) && (wr != 6'd0));
   endfunction

   // Oldest-first select: scan downward so the lowest ready index wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if ((CW'(i) < count_q) && rdya_q[i] && rdyb_q[i]) begin
            sel_found = 1'b1;
            sel_idx   = CW'(i);
         end
      end
   end

   assign issue_valid  = sel_found && !FLUSH;
   assign issue_entry  = issue_valid ? entry_q[sel_idx[IW-1:0]] : '0;
   assign issue_halt   = (count_q == CW'(DEPTH));
   assign iq_count     = count_q;
   assign overflow_err = ovf_q;
   assign do_issue     = issue_valid && exe_ready;
   assign wb_hit       = wb_valid && (wb_reg != 6'd0);

   // Next state: collapse on issue, then wakeup, then append; flush wins over all.
   always_comb begin
      entry_d     = entry_q;
      rdya_d      = rdya_q;
      rdyb_d      = rdyb_q;
      ovf_d       = ovf_q;
      count_after = count_q - {{(CW-1){1'b0}}, do_issue};
      alloc_ok    = entry_allocate_issue && (count_after < CW'(DEPTH));

      if (do_issue) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (CW'(i) >= sel_idx) begin
               entry_d[i] = entry_q[i+1];
               rdya_d[i]  = rdya_q[i+1];
               rdyb_d[i]  = rdyb_q[i+1];
            end
         end
      end

      // Wakeup touches surviving slots; slots beyond the count are don't-care.
      if (wb_hit) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entry_d[i][5:0] == wb_reg)  rdya_d[i] = 1'b1;
            if (entry_d[i][11:6] == wb_reg) rdyb_d[i] = 1'b1;
         end
      end

      if (alloc_ok) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == count_after) begin
               entry_d[i] = entry_issue;
               rdya_d[i]  = src_ready(entry_issue[5:0], busy, wb_valid, wb_reg);
               rdyb_d[i]  = src_ready(entry_issue[11:6], busy, wb_valid, wb_reg);
            end
         end
      end

      count_d = count_after + {{(CW-1){1'b0}}, alloc_ok};
      if (entry_allocate_issue && !alloc_ok) ovf_d = 1'b1;

      if (FLUSH) begin
         count_d = '0;
         ovf_d   = ovf_q;
      end
   end

   // Control state: occupancy, readiness and the sticky overflow flag.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         rdya_q  <= '0;
         rdyb_q  <= '0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         rdya_q  <= rdya_d;
         rdyb_q  <= rdyb_d;
      end
   end

   // Payload storage needs no reset: occupancy gates every use of it.
   always_ff @(posedge CLK) begin
      entry_q <= entry_d;
   end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with a scoreboard of expected issue order.
module tb_issue_queue;

   logic         CLK;
   logic         RESET;
   logic         FLUSH;
   logic         entry_allocate_issue;
   logic [169:0] entry_issue;
   logic [63:0]  busy;
   logic         wb_valid;
   logic [5:0]   wb_reg;
   logic         exe_ready;
   logic         issue_valid;
   logic [169:0] issue_entry;
   logic         issue_halt;
   logic [3:0]   iq_count;
   logic         overflow_err;

   int n_checks = 0;
   int n_fails  = 0;
   int n_hs     = 0;
   logic [169:0] sb[$];

   issue_queue #(.DEPTH(8), .WIDTH(170), .PREGS(64)) dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
      .entry_allocate_issue(entry_allocate_issue), .entry_issue(entry_issue),
      .busy(busy), .wb_valid(wb_valid), .wb_reg(wb_reg), .exe_ready(exe_ready),
      .issue_valid(issue_valid), .issue_entry(issue_entry), .issue_halt(issue_halt),
      .iq_count(iq_count), .overflow_err(overflow_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [169:0] mk(input int tag, input logic [5:0] a, input logic [5:0] b);
      logic [169:0] e;
      e = '0;
      e[169:82] = {56'h0, 32'(tag) ^ 32'hA5A5_0000};
      e[81:50]  = 32'(tag);
      e[49:18]  = 32'(tag * 4);
      e[11:6]   = b;
      e[5:0]    = a;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [169:0] act, input logic [169:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic al, input logic [169:0] e, input logic wv,
                        input logic [5:0] wr, input logic ex, input logic fl);
      entry_allocate_issue = al;
      entry_issue          = e;
      wb_valid             = wv;
      wb_reg               = wr;
      exe_ready            = ex;
      FLUSH                = fl;
   endtask

   task automatic nx();
      @(negedge CLK);
   endtask

   // Monitor: every handshake seen ahead of a rising edge must match the queue head.
   initial begin
      forever begin
         @(negedge CLK);
         #1;
         if (!RESET && issue_valid && exe_ready) begin
            n_hs++;
            if (sb.size() == 0) begin
               chk("unexpected_issue", issue_entry, '0);
               if (issue_entry == '0) begin
                  n_fails++;
                  $display("FAIL unexpected_issue: got handshake expected none");
               end
            end else begin
               chk("issue_order", issue_entry, sb.pop_front());
            end
         end
      end
   end

   initial begin
      RESET = 1'b1;
      busy  = '0;
      drive(0, '0, 0, 6'd0, 0, 0);
      #12;
      chk("rst_count", 170'(iq_count), 170'd0);
      chk("rst_valid", 170'(issue_valid), 170'd0);
      chk("rst_halt", 170'(issue_halt), 170'd0);
      chk("rst_ovf", 170'(overflow_err), 170'd0);
      chk("rst_entry", issue_entry, '0);
      nx();
      RESET = 1'b0;

      // T1: asynchronous reset with three entries queued
      drive(1, mk(1, 0, 0), 0, 0, 0, 0); nx();
      drive(1, mk(2, 0, 0), 0, 0, 0, 0); nx();
      drive(1, mk(3, 0, 0), 0, 0, 0, 0); nx();
      chk("t1_count3", 170'(iq_count), 170'd3);
      chk("t1_valid", 170'(issue_valid), 170'd1);
      drive(0, '0, 0, 0, 0, 0);
      #3 RESET = 1'b1;
      #1;
      chk("t1_rst_count", 170'(iq_count), 170'd0);
      chk("t1_rst_valid", 170'(issue_valid), 170'd0);
      chk("t1_rst_halt", 170'(issue_halt), 170'd0);
      nx();
      RESET = 1'b0;

      // T2: ready at allocate, issues the following edge
      sb.push_back(mk(10, 5, 0));
      drive(1, mk(10, 5, 0), 0, 0, 1, 0); nx();
      chk("t2_count1", 170'(iq_count), 170'd1);
      chk("t2_valid", 170'(issue_valid), 170'd1);
      drive(0, '0, 0, 0, 1, 0); nx();
      chk("t2_count0", 170'(iq_count), 170'd0);
      chk("t2_valid0", 170'(issue_valid), 170'd0);

      // T3: younger ready entry bypasses an older waiting one
      busy[7] = 1'b1;
      sb.push_back(mk(21, 0, 0));
      sb.push_back(mk(20, 7, 0));
      drive(1, mk(20, 7, 0), 0, 0, 0, 0); nx();
      drive(1, mk(21, 0, 0), 0, 0, 1, 0); nx();
      chk("t3_count2", 170'(iq_count), 170'd2);
      chk("t3_sel_e1", issue_entry, mk(21, 0, 0));
      drive(0, '0, 0, 0, 1, 0); nx();
      chk("t3_count1", 170'(iq_count), 170'd1);
      chk("t3_e0_wait", 170'(issue_valid), 170'd0);
      drive(0, '0, 1, 6'd7, 1, 0); nx();
      chk("t3_e0_woken", 170'(issue_valid), 170'd1);
      drive(0, '0, 0, 0, 1, 0); nx();
      chk("t3_count0", 170'(iq_count), 170'd0);

      // T4: writeback on the same edge as allocate marks the source ready
      busy[9] = 1'b1;
      sb.push_back(mk(30, 0, 9));
      drive(1, mk(30, 0, 9), 1, 6'd9, 1, 0); nx();
      chk("t4_count1", 170'(iq_count), 170'd1);
      chk("t4_valid", 170'(issue_valid), 170'd1);
      drive(0, '0, 0, 0, 1, 0); nx();
      chk("t4_count0", 170'(iq_count), 170'd0);

      // T5: fill under back-pressure, overflow, then issue+allocate at full
      for (int k = 0; k < 8; k++) begin
         sb.push_back(mk(40 + k, 0, 0));
         drive(1, mk(40 + k, 0, 0), 0, 0, 0, 0); nx();
      end
      chk("t5_count8", 170'(iq_count), 170'd8);
      chk("t5_halt", 170'(issue_halt), 170'd1);
      chk("t5_ovf0", 170'(overflow_err), 170'd0);
      chk("t5_hold", issue_entry, mk(40, 0, 0));
      drive(1, mk(99, 0, 0), 0, 0, 0, 0); nx();
      chk("t5_ovf1", 170'(overflow_err), 170'd1);
      chk("t5_count_stay", 170'(iq_count), 170'd8);
      sb.push_back(mk(48, 0, 0));
      drive(1, mk(48, 0, 0), 0, 0, 1, 0); nx();
      chk("t5_count_swap", 170'(iq_count), 170'd8);
      chk("t5_halt2", 170'(issue_halt), 170'd1);
      for (int k = 0; k < 8; k++) begin
         drive(0, '0, 0, 0, 1, 0); nx();
      end
      chk("t5_drained", 170'(iq_count), 170'd0);
      chk("t5_halt0", 170'(issue_halt), 170'd0);

      // T6: flush overrides concurrent allocate, wakeup and issue
      for (int k = 0; k < 5; k++) begin
         drive(1, mk(60 + k, 0, 0), 0, 0, 0, 0); nx();
      end
      chk("t6_count5", 170'(iq_count), 170'd5);
      drive(1, mk(70, 0, 0), 1, 6'd3, 1, 1);
      #1;
      chk("t6_flush_noissue", 170'(issue_valid), 170'd0);
      nx();
      chk("t6_count0", 170'(iq_count), 170'd0);
      for (int k = 0; k < 3; k++) begin
         drive(0, '0, 0, 0, 1, 0); nx();
         chk("t6_no_stale", 170'(issue_valid), 170'd0);
      end
      sb.push_back(mk(80, 0, 0));
      drive(1, mk(80, 0, 0), 0, 0, 1, 0); nx();
      drive(0, '0, 0, 0, 1, 0); nx();
      chk("t6_post_count", 170'(iq_count), 170'd0);
      chk("ovf_sticky", 170'(overflow_err), 170'd1);

      drive(0, '0, 0, 0, 0, 0);
      nx();
      nx();
      chk("sb_empty", 170'(sb.size()), 170'd0);
      chk("handshakes", 170'(n_hs), 170'd14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
